// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the conv2d_layer block: the
//               pass-control state encoding, ceil-log2, accumulator width and
//               signed saturation bounds derived from the word width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest accumulator the saturation helpers can describe.
  localparam int c_bound_w = 128;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Full-precision width for K*K products of 2*bw bits plus a shifted bias.
  function automatic int acc_width(input int bw, input int k);
    return 2 * bw + clog2(k * k) + 1;
  endfunction

  function automatic logic signed [c_bound_w-1:0] sat_max(input int bw);
    return (128'sd1 <<< (bw - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [c_bound_w-1:0] sat_min(input int bw);
    return -(128'sd1 <<< (bw - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_pe.sv
// ============================================================================
// Module      : conv_pe
// Description : One output channel of the convolution. Purely combinational:
//               K*K windowed dot product, bias add, arithmetic right shift by
//               FRAC, signed saturation to BITWIDTH and optional ReLU clamp.
// Config      : CONV_RELU_EN - when defined, negative results are written as 0.
// Ports       : window  - K*K pixels, tap t = K*v+u holds pix(r+u-P, c+v-P)
//               weights - K*K weights, same tap ordering as window
//               bias    - channel bias (integer part, shifted left by FRAC)
//               result  - saturated output word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_pe
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int K        = 5,
  parameter int FRAC     = 0
) (
  input  logic [K*K*BITWIDTH-1:0] window,
  input  logic [K*K*BITWIDTH-1:0] weights,
  input  logic [BITWIDTH-1:0]     bias,
  output logic [BITWIDTH-1:0]     result
);

  localparam int c_prod_w = 2 * BITWIDTH;
  localparam int c_acc_w  = acc_width(BITWIDTH, K);

  localparam logic signed [c_acc_w-1:0] c_sat_max = c_acc_w'(sat_max(BITWIDTH));
  localparam logic signed [c_acc_w-1:0] c_sat_min = c_acc_w'(sat_min(BITWIDTH));

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_acc_w-1:0]  w_acc;
  logic signed [c_acc_w-1:0]  w_shift;
  logic [BITWIDTH-1:0]        w_res;

  always_comb begin
    w_prod  = '0;
    w_acc   = '0;
    for (int t = 0; t < K * K; t++) begin
      // Operands are sign-extended before the multiply so the product is exact.
      w_prod = c_prod_w'($signed(window[t*BITWIDTH +: BITWIDTH]))
             * c_prod_w'($signed(weights[t*BITWIDTH +: BITWIDTH]));
      w_acc  = w_acc + c_acc_w'(w_prod);
    end
    w_acc   = w_acc + (c_acc_w'($signed(bias)) <<< FRAC);
    w_shift = w_acc >>> FRAC;

    w_res = w_shift[BITWIDTH-1:0];
    if (w_shift > c_sat_max) begin
      w_res = {1'b0, {(BITWIDTH-1){1'b1}}};
    end else if (w_shift < c_sat_min) begin
      w_res = {1'b1, {(BITWIDTH-1){1'b0}}};
    end

`ifdef CONV_RELU_EN
    if (w_res[BITWIDTH-1]) w_res = '0;
`else
`endif
    result = w_res;
  end

endmodule

`default_nettype wire

// File: rtl/conv2d_layer.sv
// ============================================================================
// Module      : conv2d_layer
// Description : Same-size, zero-padded 2-D convolution of one IMG x IMG plane
//               with N_CH kernels of K x K, one output pixel per cycle for all
//               channels in parallel. Enable / finished / reply handshake.
// Config      : CONV_RELU_EN - when defined, negative results are written as 0.
// Ports       : clk, reset (async, active low)
//               image    - pixel (i,j) at word IMG*j+i
//               kernels  - weight (ch,i,j) at word ch*K*K+K*j+i
//               bias     - bias of channel ch at word ch
//               enable, reply_from_next_device - handshake inputs
//               featuremap - output (ch,i,j) at word ch*IMG*IMG+IMG*j+i
//               finished_for_next_device - high while results are ready
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2d_layer
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int IMG      = 28,
  parameter int K        = 5,
  parameter int N_CH     = 2,
  parameter int FRAC     = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [IMG*IMG*BITWIDTH-1:0]      image,
  input  logic [N_CH*K*K*BITWIDTH-1:0]     kernels,
  input  logic [N_CH*BITWIDTH-1:0]         bias,
  input  logic                             enable,
  input  logic                             reply_from_next_device,
  output logic [N_CH*IMG*IMG*BITWIDTH-1:0] featuremap,
  output logic                             finished_for_next_device
);

  localparam int c_pad   = (K - 1) / 2;
  localparam int c_cnt_w = (clog2(IMG) < 1) ? 1 : clog2(IMG);
  localparam int c_idx_w = (clog2(IMG * IMG) < 1) ? 1 : clog2(IMG * IMG);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [c_cnt_w-1:0]              r_row;
  logic [c_cnt_w-1:0]              r_col;
  logic [IMG*IMG*BITWIDTH-1:0]     r_image;
  logic [N_CH*K*K*BITWIDTH-1:0]    r_kernels;
  logic [N_CH*BITWIDTH-1:0]        r_bias;
  logic [K*K*BITWIDTH-1:0]         w_window;
  logic [N_CH*BITWIDTH-1:0]        w_result;
  logic                            w_last_pixel;

  assign w_last_pixel = (r_row == c_cnt_w'(IMG - 1)) && (r_col == c_cnt_w'(IMG - 1));
  assign finished_for_next_device = (r_state == DONE);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (enable) w_state_nxt = LOAD;
      LOAD: w_state_nxt = RUN;
      RUN:  if (w_last_pixel) w_state_nxt = DONE;
      DONE: if (reply_from_next_device) w_state_nxt = enable ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Window extraction: taps outside the plane read as zero.
  // --------------------------------------------------------------------------
  for (genvar gu = 0; gu < K; gu++) begin : g_tap_row
    for (genvar gv = 0; gv < K; gv++) begin : g_tap_col
      int                 w_prow;
      int                 w_pcol;
      logic [c_idx_w-1:0] w_idx;
      logic               w_inside;

      assign w_prow   = int'(r_row) + gu - c_pad;
      assign w_pcol   = int'(r_col) + gv - c_pad;
      assign w_inside = (w_prow >= 0) && (w_prow < IMG) && (w_pcol >= 0) && (w_pcol < IMG);
      assign w_idx    = c_idx_w'(w_pcol * IMG + w_prow);
      assign w_window[(K*gv+gu)*BITWIDTH +: BITWIDTH] =
        w_inside ? r_image[w_idx*BITWIDTH +: BITWIDTH] : '0;
    end
  end

  // --------------------------------------------------------------------------
  // One processing element per output channel
  // --------------------------------------------------------------------------
  for (genvar gc = 0; gc < N_CH; gc++) begin : g_pe
    conv_pe #(
      .BITWIDTH (BITWIDTH),
      .K        (K),
      .FRAC     (FRAC)
    ) u_pe (
      .window  (w_window),
      .weights (r_kernels[gc*K*K*BITWIDTH +: K*K*BITWIDTH]),
      .bias    (r_bias[gc*BITWIDTH +: BITWIDTH]),
      .result  (w_result[gc*BITWIDTH +: BITWIDTH])
    );
  end

  // --------------------------------------------------------------------------
  // State, operand capture, counters and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_image    <= '0;
      r_kernels  <= '0;
      r_bias     <= '0;
      featuremap <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LOAD: begin
          r_image   <= image;
          r_kernels <= kernels;
          r_bias    <= bias;
          r_row     <= '0;
          r_col     <= '0;
        end
        RUN: begin
          for (int ch = 0; ch < N_CH; ch++) begin
            featuremap[(ch*IMG*IMG + IMG*int'(r_col) + int'(r_row))*BITWIDTH +: BITWIDTH]
              <= w_result[ch*BITWIDTH +: BITWIDTH];
          end
          if (r_col == c_cnt_w'(IMG - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_layer.sv
// ============================================================================
// Module      : tb_conv2d_layer
// Description : Directed, table-driven bench for conv2d_layer with default
//               parameters (32-bit words, 28x28 plane, 5x5 kernels, 2 ch).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv2d_layer;

  localparam int BW   = 32;
  localparam int IMG  = 28;
  localparam int K    = 5;
  localparam int NCH  = 2;
  localparam int PASS_EDGES = IMG * IMG + 1;

`ifdef CONV_RELU_EN
  localparam logic [31:0] EXP_NEG5   = 32'h0000_0000;
  localparam logic [31:0] EXP_MINSAT = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG5   = 32'hFFFF_FFFB;
  localparam logic [31:0] EXP_MINSAT = 32'h8000_0000;
`endif

  logic                          clk;
  logic                          reset;
  logic [IMG*IMG*BW-1:0]         image;
  logic [NCH*K*K*BW-1:0]         kernels;
  logic [NCH*BW-1:0]             bias;
  logic                          enable;
  logic                          reply;
  logic [NCH*IMG*IMG*BW-1:0]     featuremap;
  logic                          finished;

  int n_vec;
  int n_fail;

  conv2d_layer dut (
    .clk                      (clk),
    .reset                    (reset),
    .image                    (image),
    .kernels                  (kernels),
    .bias                     (bias),
    .enable                   (enable),
    .reply_from_next_device   (reply),
    .featuremap               (featuremap),
    .finished_for_next_device (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tid;
    int          ch;
    int          i;
    int          j;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [31:0] fm(input int ch, input int i, input int j);
    return featuremap[(ch*IMG*IMG + IMG*j + i)*BW +: BW];
  endfunction

  function automatic int ones_count(input int i, input int j);
    int rows, cols;
    rows = ((i + 2 > IMG - 1) ? IMG - 1 : i + 2) - ((i - 2 < 0) ? 0 : i - 2) + 1;
    cols = ((j + 2 > IMG - 1) ? IMG - 1 : j + 2) - ((j - 2 < 0) ? 0 : j - 2) + 1;
    return rows * cols;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_pix(input int i, input int j, input logic [31:0] v);
    image[(IMG*j + i)*BW +: BW] = v;
  endtask

  task automatic set_w(input int ch, input int u, input int v, input logic [31:0] w);
    kernels[(ch*K*K + K*v + u)*BW +: BW] = w;
  endtask

  task automatic configure(input int tid);
    image = '0; kernels = '0; bias = '0;
    for (int i = 0; i < IMG; i++) begin
      for (int j = 0; j < IMG; j++) begin
        case (tid)
          1: set_pix(i, j, 32'(28*j + i));
          2: set_pix(i, j, 32'd1);
          3: set_pix(i, j, 32'd5);
          4: set_pix(i, j, 32'h7FFF_FFFF);
          5: set_pix(i, j, 32'h8000_0000);
          6: set_pix(i, j, 32'(100*i + j));
          default: ;
        endcase
      end
    end
    case (tid)
      1, 6: set_w(0, 2, 2, 32'd1);
      2: begin
        for (int u = 0; u < K; u++)
          for (int v = 0; v < K; v++) set_w(1, u, v, 32'd1);
        bias[0 +: BW] = 32'd7;
      end
      3: set_w(0, 2, 2, 32'hFFFF_FFFF);
      4: begin set_w(0, 2, 2, 32'd2); set_w(1, 2, 2, 32'hFFFF_FFFE); end
      5: set_w(0, 2, 2, 32'd2);
      default: ;
    endcase
  endtask

  // Counts edges after the sampling edge until finished rises (bounded).
  task automatic wait_done(input bit scramble, output int edges);
    edges = 0;
    while (finished !== 1'b1 && edges < 2000) begin
      @(posedge clk); #1;
      edges++;
      if (scramble && edges == 1) begin
        image = '0; kernels = '0; bias = '0;
      end
    end
  endtask

  task automatic start_pass(input bit scramble, output int edges);
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    wait_done(scramble, edges);
  endtask

  task automatic release_done();
    @(negedge clk); reply = 1'b1;
    @(posedge clk); #1 reply = 1'b0;
    chk("release_finished", 32'(finished), 32'd0);
  endtask

  initial begin
    int edges;
    n_vec = 0; n_fail = 0;
    reset = 1'b0; enable = 1'b0; reply = 1'b0;
    image = '0; kernels = '0; bias = '0;

    tbl[0]  = '{2, 1, 10, 10, 32'd25};
    tbl[1]  = '{2, 1,  0,  0, 32'd9};
    tbl[2]  = '{2, 1, 27, 27, 32'd9};
    tbl[3]  = '{2, 1,  0, 27, 32'd9};
    tbl[4]  = '{2, 1,  0, 14, 32'd15};
    tbl[5]  = '{2, 1, 14, 27, 32'd15};
    tbl[6]  = '{2, 1,  0,  1, 32'd12};
    tbl[7]  = '{2, 1,  1,  1, 32'd16};
    tbl[8]  = '{2, 0,  5,  5, 32'd7};
    tbl[9]  = '{2, 0,  0,  0, 32'd7};
    tbl[10] = '{3, 0,  0,  0, EXP_NEG5};
    tbl[11] = '{3, 0, 13, 13, EXP_NEG5};
    tbl[12] = '{3, 0, 27,  0, EXP_NEG5};
    tbl[13] = '{4, 0,  0,  0, 32'h7FFF_FFFF};
    tbl[14] = '{4, 0, 12, 20, 32'h7FFF_FFFF};
    tbl[15] = '{4, 1,  3,  3, EXP_MINSAT};
    tbl[16] = '{5, 0,  0,  0, EXP_MINSAT};
    tbl[17] = '{5, 0, 27, 27, EXP_MINSAT};
    tbl[18] = '{5, 1, 27, 27, 32'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_featuremap_nonzero", 32'(|featuremap), 32'd0);
    chk("reset_finished", 32'(finished), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Identity kernel; inputs scrambled after capture must not matter.
    configure(1);
    start_pass(1'b1, edges);
    chk("identity_latency", 32'(edges), 32'(PASS_EDGES));
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++)
        chk($sformatf("identity(%0d,%0d)", i, j), fm(0, i, j), 32'(28*j + i));
    chk("identity_ch1_zero", fm(1, 7, 9), 32'd0);
    release_done();

    // Table-driven passes; the last one stays in DONE for the hold test.
    for (int tid = 2; tid <= 5; tid++) begin
      configure(tid);
      start_pass(1'b0, edges);
      chk($sformatf("latency_t%0d", tid), 32'(edges), 32'(PASS_EDGES));
      for (int n = 0; n < $size(tbl); n++)
        if (tbl[n].tid == tid)
          chk($sformatf("t%0d_ch%0d(%0d,%0d)", tid, tbl[n].ch, tbl[n].i, tbl[n].j),
              fm(tbl[n].ch, tbl[n].i, tbl[n].j), tbl[n].exp);
      if (tid != 5) release_done();
    end

    // Hold in DONE with reply low.
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      chk("hold_finished", 32'(finished), 32'd1);
      chk("hold_featuremap", fm(0, 4, 9), EXP_MINSAT);
    end

    // Back-to-back restart from DONE.
    configure(6);
    @(negedge clk); reply = 1'b1; enable = 1'b1;
    @(posedge clk); #1 reply = 1'b0; enable = 1'b0;
    chk("b2b_finished_drop", 32'(finished), 32'd0);
    wait_done(1'b0, edges);
    chk("b2b_latency", 32'(edges), 32'(PASS_EDGES));
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++)
        chk($sformatf("b2b(%0d,%0d)", i, j), fm(0, i, j), 32'(100*i + j));
    release_done();

    // Reset in the middle of RUN, then a clean rerun.
    configure(2);
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    repeat (300) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrun_reset_featuremap", 32'(|featuremap), 32'd0);
    chk("midrun_reset_finished", 32'(finished), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(finished), 32'd0);
    start_pass(1'b0, edges);
    chk("rerun_latency", 32'(edges), 32'(PASS_EDGES));
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++)
        chk($sformatf("rerun_ones(%0d,%0d)", i, j), fm(1, i, j), 32'(ones_count(i, j)));
    chk("rerun_bias", fm(0, 27, 0), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv2d_layer.md
# conv2d_layer

Parametrised successor of the first convolution stage: a same-size, zero-padded 2-D convolution over one IMG×IMG input plane with N_CH independent K×K kernels. Each kernel has a per-channel bias, fixed-point scaling and signed saturation, and optional ReLU. It computes one output pixel per cycle for all channels in parallel. It sits between the image source and the pooling stage and uses the same enable / finished / reply handshake.

## Interface
- BITWIDTH, 32: signed two's-complement word width for pixels, weights, bias and outputs.
- IMG, 28: input and output plane edge length.
- K, 5: kernel edge length; must be odd.
- N_CH, 2: number of kernels / output channels.
- FRAC, 0: fractional bits of the fixed-point format; the accumulator is shifted right by FRAC.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- image  in  IMG·IMG·BITWIDTH  pixel (row i, col j) at word index IMG·j+i.
- kernels  in  N_CH·K·K·BITWIDTH  weight (ch, i, j) at word index ch·K·K+K·j+i.
- bias  in  N_CH·BITWIDTH  bias for channel ch at word index ch.
- enable  in  1  request to start a pass.
- reply_from_next_device  in  1  consumer has taken featuremap.
- featuremap  out  N_CH·IMG·IMG·BITWIDTH  output (ch, i, j) at word index ch·IMG·IMG+IMG·j+i; registered.
- finished_for_next_device  out  1  high exactly while in DONE.

## Operation
- States:
  - IDLE → LOAD when enable is high.
  - LOAD → RUN unconditionally.
  - RUN → DONE after the pixel (IMG-1, IMG-1) is written.
  - DONE → LOAD if reply_from_next_device and enable are both high; → IDLE if reply_from_next_device is high and enable is low; otherwise stay in DONE.
- LOAD: register image, kernels and bias into internal arrays in one edge. Inputs may change afterwards.
- RUN: row counter r and column counter c, both 0..IMG-1. c increments each cycle; it wraps to 0 and r increments when c = IMG-1.
- Each RUN cycle writes featuremap(ch, r, c) for every ch:
  - acc = Σ kernel(ch,u,v)·pix(r+u-P, c+v-P), with P = (K-1)/2. Out-of-range pixels read as 0 (zero padding).
  - acc += bias(ch) << FRAC.
  - Products are full 2·BITWIDTH signed. The accumulator is 2·BITWIDTH + clog2(K·K) + 1 bits, with no intermediate overflow.
  - result = acc >>> FRAC (arithmetic shift), then saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Every output word is written exactly once per pass, so there is no clearing between passes. featuremap holds its values through DONE and IDLE until overwritten.
- enable is ignored in LOAD and RUN. reply_from_next_device is ignored outside DONE.
- Reset value of all outputs is 0: featuremap, finished_for_next_device, internal arrays and counters. State resets to IDLE.
- Reset asserted at any point, including mid-RUN, aborts the pass immediately and returns all of the above to reset values.

## Timing
- Sampling edge n (IDLE, enable high) → LOAD during cycle n+1.
- Inputs are captured at edge n+1.
- Outputs are written at edges n+2 … n+1+IMG².
- finished_for_next_device goes high after edge n+1+IMG². For the defaults, that is 785 edges after sampling.
- reply_from_next_device sampled high in DONE → finished_for_next_device drops after that same edge.
- Back-to-back passes (reply and enable both high) cost IMG²+2 cycles each.
- One pixel per cycle. No pipelining is required; the single-edge combinational MAC tree per channel is accepted.

## Configuration
- CONV_RELU_EN defined: a negative saturated result is written as 0.
- CONV_RELU_EN undefined: the signed saturated result is written unchanged.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - clog2 and accumulator-width functions;
  - saturation bounds as functions of BITWIDTH.
- Sub-module conv_pe: one channel's K×K windowed dot product plus bias, shift, saturate and the CONV_RELU_EN clamp. It is purely combinational and instantiated N_CH times. The top level owns the FSM, counters, window extraction with padding, and output registers.

## Test plan
- Identity kernel (centre 1, rest 0), bias 0, image word = 28·j+i → channel 0 output equals image; finished high exactly 785 edges after enable sampled.
- All-ones image and kernel on channel 1 → interior 25, corner 9, edge-middle 15, (0,1) 12, (1,1) 16.
- Centre weight -1, image all 5, bias 0 → with CONV_RELU_EN all outputs 0; without, all 0xFFFFFFFB.
- Image all 0x7FFFFFFF, centre weight 2, bias 0 → 0x7FFFFFFF. Image all 0x80000000, centre weight 2, bias 0 → 0x80000000 without CONV_RELU_EN.
- Hold reply low 50 cycles in DONE → finished and featuremap stable. Then reply and enable high together → LOAD next cycle, finished low after that edge, second pass correct.
- Assert reset at RUN cycle 300 → featuremap all 0, finished 0, IDLE. Release and rerun → correct full result.
